// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: widths, opcode map and FSM states.
package alu_pkg;

    localparam int DW  = 16;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD   = 4'd0;
    localparam logic [OPW-1:0] OP_SUB   = 4'd1;
    localparam logic [OPW-1:0] OP_AND   = 4'd2;
    localparam logic [OPW-1:0] OP_OR    = 4'd3;
    localparam logic [OPW-1:0] OP_NOT   = 4'd4;
    localparam logic [OPW-1:0] OP_SHL   = 4'd5;
    localparam logic [OPW-1:0] OP_SHR   = 4'd6;
    localparam logic [OPW-1:0] OP_MPY   = 4'd7;
    localparam logic [OPW-1:0] OP_PASSB = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// 16-iteration unsigned shift-add multiplier; product is presented together with done
// on the final iteration so the caller can register it on the same edge.
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] product,
    output logic            done
);

    logic [2*DW-1:0] mcand_q;
    logic [DW-1:0]   mplier_q;
    logic [2*DW-1:0] prod_q;
    logic [3:0]      cnt_q;
    logic            running_q;
    logic [2*DW-1:0] prodNext;

    assign prodNext = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign product  = prodNext;
    assign done     = running_q && (cnt_q == 4'd15);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (go) begin
            mcand_q   <= {{DW{1'b0}}, a};
            mplier_q  <= b;
            prod_q    <= '0;
            cnt_q     <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            prod_q   <= prodNext;
            mcand_q  <= {mcand_q[2*DW-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[DW-1:1]};
            cnt_q    <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU feeding the accumulator: single-cycle ops write immediately,
// MPY runs the shift-add multiplier and writes back from the WB state.
module alu_seq
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  acc_data,
    input  logic [DW-1:0]  mbr_data,
    output logic [DW-1:0]  alu2acc,
    output logic           acc_alu_io_rw,
    output logic [DW-1:0]  mr_data,
    output logic           busy,
    output logic           flag_z,
    output logic           flag_n,
    output logic           flag_c,
    output logic           flag_v,
    output logic           illegal_op
);

    state_e          state_q, state_d;
    logic [DW-1:0]   result_q, result_d;
    logic [DW-1:0]   mr_q, mr_d;
    logic            strobe_q, strobe_d;
    logic            z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic            illegal_q, illegal_d;

    logic            mulGo;
    logic            mulDone;
    logic [2*DW-1:0] mulProd;

    logic [DW-1:0]   aluRes;
    logic            aluC, aluV, aluLegal;
    logic [DW:0]     sumExt, diffExt;

    alu_mul_seq u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (mulGo),
        .a       (acc_data),
        .b       (mbr_data),
        .product (mulProd),
        .done    (mulDone)
    );

    // Combinational result for the single-cycle opcodes; the 17-bit forms give carry/borrow.
    always_comb begin
        aluRes   = '0;
        aluC     = 1'b0;
        aluV     = 1'b0;
        aluLegal = 1'b1;
        sumExt   = {1'b0, acc_data} + {1'b0, mbr_data};
        diffExt  = {1'b0, acc_data} - {1'b0, mbr_data};
        case (op)
            OP_ADD: begin
                aluRes = sumExt[DW-1:0];
                aluC   = sumExt[DW];
                aluV   = (acc_data[DW-1] == mbr_data[DW-1]) && (sumExt[DW-1] != acc_data[DW-1]);
            end
            OP_SUB: begin
                aluRes = diffExt[DW-1:0];
                aluC   = diffExt[DW];
                aluV   = (acc_data[DW-1] != mbr_data[DW-1]) && (diffExt[DW-1] != acc_data[DW-1]);
            end
            OP_AND:   aluRes = acc_data & mbr_data;
            OP_OR:    aluRes = acc_data | mbr_data;
            OP_NOT:   aluRes = ~acc_data;
            OP_SHL: begin
                aluRes = {acc_data[DW-2:0], 1'b0};
                aluC   = acc_data[DW-1];
            end
            OP_SHR: begin
                aluRes = {1'b0, acc_data[DW-1:1]};
                aluC   = acc_data[0];
            end
            OP_MPY:   aluLegal = 1'b1;
            OP_PASSB: aluRes = mbr_data;
            default:  aluLegal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        mr_d      = mr_q;
        strobe_d  = 1'b0;
        z_d       = z_q;
        n_d       = n_q;
        c_d       = c_q;
        v_d       = v_q;
        illegal_d = 1'b0;
        mulGo     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MPY) begin
                        mulGo   = 1'b1;
                        state_d = ST_MUL;
                    end else if (aluLegal) begin
                        result_d = aluRes;
                        strobe_d = 1'b1;
                        z_d      = (aluRes == '0);
                        n_d      = aluRes[DW-1];
                        c_d      = aluC;
                        v_d      = aluV;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mulDone) begin
                    result_d = mulProd[DW-1:0];
                    mr_d     = mulProd[2*DW-1:DW];
                    strobe_d = 1'b1;
                    z_d      = (mulProd[DW-1:0] == '0);
                    n_d      = mulProd[DW-1];
                    c_d      = (mulProd[2*DW-1:DW] != '0);
                    v_d      = 1'b0;
                    state_d  = ST_WB;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            mr_q      <= '0;
            strobe_q  <= 1'b0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            mr_q      <= mr_d;
            strobe_q  <= strobe_d;
            z_q       <= z_d;
            n_q       <= n_d;
            c_q       <= c_d;
            v_q       <= v_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu2acc       = result_q;
    assign acc_alu_io_rw = strobe_q;
    assign mr_data       = mr_q;
    assign busy          = (state_q == ST_MUL);
    assign flag_z        = z_q;
    assign flag_n        = n_q;
    assign flag_c        = c_q;
    assign flag_v        = v_q;
    assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model checked every cycle, plus directed literal checks.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [15:0] acc_data;
    logic [15:0] mbr_data;
    logic [15:0] alu2acc;
    logic        acc_alu_io_rw;
    logic [15:0] mr_data;
    logic        busy;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;
    bit checkOn = 0;

    int  mResult, mMr, mulLeft;
    bit  mStrobe, mIll, mZ, mN, mC, mV, wbHold;
    longint mulA, mulB;

    alu_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .op            (op),
        .acc_data      (acc_data),
        .mbr_data      (mbr_data),
        .alu2acc       (alu2acc),
        .acc_alu_io_rw (acc_alu_io_rw),
        .mr_data       (mr_data),
        .busy          (busy),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start    = s;
        op       = o;
        acc_data = a;
        mbr_data = b;
    endtask

    function automatic int toSigned(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    task automatic modelWrite(input int r, input bit c, input bit v);
        mResult = r;
        mZ      = (r == 0);
        mN      = (r >= 32768);
        mC      = c;
        mV      = v;
        mStrobe = 1'b1;
    endtask

    // Reference model: what each edge must produce, from plain integer arithmetic.
    always @(posedge clk) begin
        int a, b, s;
        longint p;
        if (!rst_n) begin
            mResult = 0; mMr = 0; mStrobe = 0; mIll = 0;
            mZ = 0; mN = 0; mC = 0; mV = 0;
            mulLeft = 0; wbHold = 0;
        end else begin
            mStrobe = 0;
            mIll    = 0;
            if (mulLeft > 0) begin
                mulLeft--;
                if (mulLeft == 0) begin
                    p   = mulA * mulB;
                    mMr = int'(p / 65536);
                    modelWrite(int'(p % 65536), mMr != 0, 1'b0);
                    wbHold = 1;
                end
            end else if (wbHold) begin
                wbHold = 0;
            end else if (start) begin
                a = int'(acc_data);
                b = int'(mbr_data);
                case (int'(op))
                    0: begin
                        s = toSigned(a) + toSigned(b);
                        modelWrite((a + b) % 65536, (a + b) > 65535, (s > 32767) || (s < -32768));
                    end
                    1: begin
                        s = toSigned(a) - toSigned(b);
                        modelWrite((a - b + 65536) % 65536, a < b, (s > 32767) || (s < -32768));
                    end
                    2: modelWrite(a & b, 0, 0);
                    3: modelWrite(a | b, 0, 0);
                    4: modelWrite(65535 - a, 0, 0);
                    5: modelWrite((a * 2) % 65536, a >= 32768, 0);
                    6: modelWrite(a / 2, (a % 2) == 1, 0);
                    7: begin
                        mulA    = longint'(a);
                        mulB    = longint'(b);
                        mulLeft = 16;
                    end
                    8: modelWrite(b, 0, 0);
                    default: mIll = 1;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("model_alu2acc", alu2acc, mResult);
            checkOutput("model_strobe", acc_alu_io_rw, mStrobe);
            checkOutput("model_mr", mr_data, mMr);
            checkOutput("model_busy", busy, mulLeft > 0);
            checkOutput("model_flags", {flag_z, flag_n, flag_c, flag_v}, {mZ, mN, mC, mV});
            checkOutput("model_illegal", illegal_op, mIll);
        end
    end

    initial begin
        int nStrobe;
        rst_n = 1'b0; start = 1'b0; op = 4'd0; acc_data = 16'd0; mbr_data = 16'd0;

        @(negedge clk);
        checkOn = 1;
        checkOutput("reset_alu2acc", alu2acc, 32'h0);
        checkOutput("reset_strobe", acc_alu_io_rw, 32'h0);
        checkOutput("reset_busy", busy, 32'h0);
        rst_n = 1'b1;

        // ADD overflow into the sign bit
        applyStimulus(1'b1, 4'd0, 16'h7FFF, 16'h0001);
        applyStimulus(1'b0, 4'd0, 16'h7FFF, 16'h0001);
        checkOutput("add_result", alu2acc, 32'h8000);
        checkOutput("add_strobe", acc_alu_io_rw, 32'h1);
        checkOutput("add_zncv", {flag_z, flag_n, flag_c, flag_v}, 32'b0101);
        applyStimulus(1'b0, 4'd0, 16'h7FFF, 16'h0001);
        checkOutput("add_strobe_drop", acc_alu_io_rw, 32'h0);

        // SUB with borrow, then equal operands
        applyStimulus(1'b1, 4'd1, 16'h0003, 16'h0005);
        applyStimulus(1'b1, 4'd1, 16'h1234, 16'h1234);
        checkOutput("sub_result", alu2acc, 32'hFFFE);
        checkOutput("sub_c_n", {flag_c, flag_n}, 32'b11);
        applyStimulus(1'b0, 4'd0, 16'h0, 16'h0);
        checkOutput("sub_zero", alu2acc, 32'h0);
        checkOutput("sub_z", flag_z, 32'h1);
        checkOutput("b2b_strobe", acc_alu_io_rw, 32'h1);

        // MPY with starts issued while busy and in write-back
        applyStimulus(1'b1, 4'd7, 16'h1234, 16'h0100);
        nStrobe = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus((k == 8) || (k == 17), 4'd0, 16'h1234, 16'h0100);
            if (acc_alu_io_rw) nStrobe++;
            checkOutput("mpy_busy", busy, (k <= 16) ? 32'h1 : 32'h0);
            if (k == 17) begin
                checkOutput("mpy_lo", alu2acc, 32'h3400);
                checkOutput("mpy_hi", mr_data, 32'h0012);
                checkOutput("mpy_c", flag_c, 32'h1);
                checkOutput("mpy_strobe", acc_alu_io_rw, 32'h1);
            end
        end
        checkOutput("mpy_one_strobe", nStrobe, 32'd1);

        // MPY max operands, operands change mid-run
        applyStimulus(1'b1, 4'd7, 16'hFFFF, 16'hFFFF);
        for (int k = 1; k <= 18; k++) begin
            applyStimulus(1'b0, 4'd0, (k >= 5) ? 16'h0000 : 16'hFFFF, (k >= 5) ? 16'h0003 : 16'hFFFF);
            if (k == 17) begin
                checkOutput("mpyff_lo", alu2acc, 32'h0001);
                checkOutput("mpyff_hi", mr_data, 32'hFFFE);
            end
        end

        // Reset in the middle of a multiply
        applyStimulus(1'b1, 4'd7, 16'h1234, 16'h5678);
        nStrobe = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 4'd0, 16'h1234, 16'h5678);
            if (k == 8) rst_n = 1'b0;
            if (k == 9) begin
                checkOutput("rst_busy", busy, 32'h0);
                checkOutput("rst_alu2acc", alu2acc, 32'h0);
                checkOutput("rst_mr", mr_data, 32'h0);
                rst_n = 1'b1;
            end
            if (acc_alu_io_rw) nStrobe++;
        end
        checkOutput("rst_no_strobe", nStrobe, 32'd0);
        applyStimulus(1'b1, 4'd0, 16'h0002, 16'h0003);
        applyStimulus(1'b0, 4'd0, 16'h0, 16'h0);
        checkOutput("post_rst_add", alu2acc, 32'h0005);

        // Illegal opcode keeps result and flags
        applyStimulus(1'b1, 4'd1, 16'h0003, 16'h0005);
        applyStimulus(1'b1, 4'hC, 16'h1111, 16'h2222);
        applyStimulus(1'b0, 4'd0, 16'h0, 16'h0);
        checkOutput("ill_pulse", illegal_op, 32'h1);
        checkOutput("ill_no_strobe", acc_alu_io_rw, 32'h0);
        checkOutput("ill_keep_result", alu2acc, 32'hFFFE);
        checkOutput("ill_keep_flags", {flag_z, flag_n, flag_c, flag_v}, 32'b0110);
        applyStimulus(1'b0, 4'd0, 16'h0, 16'h0);
        checkOutput("ill_pulse_drop", illegal_op, 32'h0);

        // SHL shifts the top bit into carry
        applyStimulus(1'b1, 4'd5, 16'h8001, 16'h0);
        applyStimulus(1'b0, 4'd0, 16'h0, 16'h0);
        checkOutput("shl_result", alu2acc, 32'h0002);
        checkOutput("shl_c", flag_c, 32'h1);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
            rst_n = ($urandom_range(0, 199) != 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'd0, 16'h0, 16'h0);

        checkOn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle arithmetic/logic unit of the simple CPU datapath. Sits directly upstream of the accumulator register (ACC).
- Operand A is the current ACC output; operand B comes from the memory buffer register.
- Produces the 16-bit result on alu2acc with a one-cycle write strobe acc_alu_io_rw. The strobe is 1 = write ACC, 0 = ACC holds.
- Single-cycle ops complete in one clock. MPY is a 16-iteration shift-add sequence that raises busy while it runs.

Parameters:
- DW, 16, datapath width. Only 16 is supported; kept symbolic for the package.
- OPW, 4, opcode width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low (sampled on posedge clk)
- start  in  1  op request from control unit; sampled only when busy=0
- op  in  4  opcode, sampled with start
- acc_data  in  16  operand A (ACC output)
- mbr_data  in  16  operand B (memory buffer)
- alu2acc  out  16  registered result to ACC
- acc_alu_io_rw  out  1  one-cycle ACC write strobe
- mr_data  out  16  high half of the last MPY product; otherwise holds
- busy  out  1  high while MPY is iterating
- flag_z/flag_n/flag_c/flag_v  out  1 each  status flags, registered with each write
- illegal_op  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset: when rst_n=0 at a posedge, all outputs and internal state clear to 0 and the FSM goes to IDLE. This applies mid-MPY: the operation is aborted and no write strobe is issued.
- FSM states: IDLE, MUL, WB.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 NOT: ~A
  - 5 SHL: A<<1
  - 6 SHR: A>>1, logical
  - 7 MPY: unsigned A*B, 32-bit product
  - 8 PASSB: B
  - 9–15: illegal
- Single-cycle op: start=1 in IDLE at edge E0.
  - alu2acc, flags and acc_alu_io_rw=1 are valid in the cycle after E0; the strobe drops after one cycle.
  - FSM stays IDLE, so back-to-back starts give back-to-back strobes.
- MPY: start at E0.
  - State goes to MUL with busy=1; operands are latched at E0.
  - One shift-add iteration per edge, E1..E16. At E16 go to WB.
  - In WB: alu2acc = product[15:0], mr_data = product[31:16], acc_alu_io_rw=1, busy=0.
  - Next edge returns to IDLE. Strobe cycle = E0+17 cycles.
- start while busy=1 or while in WB is ignored: no queueing, no error.
- Operands are latched at start. Changes to acc_data/mbr_data during MUL have no effect.
- Illegal opcode: illegal_op=1 for one cycle. No strobe, alu2acc and flags unchanged.
- Flags are updated only on a strobe:
  - z = (result==0)
  - n = result[15]
  - c: ADD carry-out; SUB borrow (A<B); SHL = A[15]; SHR = A[0]; MPY = (mr!=0); else 0
  - v: ADD/SUB two's-complement overflow, else 0
- alu2acc holds its last value between strobes; ACC ignores it while the strobe is 0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_PASSB
  - FSM state encoding
  - DW/OPW constants
- One natural sub-module, alu_mul_seq: 16-cycle unsigned shift-add multiplier.
  - Inputs: clk, rst_n, go, a, b.
  - Outputs: product[31:0], done.
  - alu_seq instantiates it and owns the strobe/flag logic.

Test Plan:
- ADD: A=0x7FFF, B=0x0001, start one cycle -> next cycle alu2acc=0x8000, strobe=1 for exactly one cycle, n=1, v=1, c=0, z=0.
- SUB: A=0x0003, B=0x0005 -> alu2acc=0xFFFE, c=1 (borrow), n=1. Then SUB A=B=0x1234 -> alu2acc=0, z=1.
- MPY: A=0x1234, B=0x0100.
  - busy=1 for cycles E0+1..E0+16.
  - Strobe at E0+17 with alu2acc=0x3400, mr_data=0x0012, c=1.
  - A second start issued during busy is ignored: exactly one strobe.
- MPY 0xFFFF*0xFFFF -> alu2acc=0x0001, mr_data=0xFFFE. Change acc_data mid-MUL -> result unaffected.
- Reset mid-MPY: assert rst_n=0 at iteration 8 -> next edge busy=0, alu2acc=0, no strobe. After release, an ADD works normally.
- Illegal op=0xC -> illegal_op pulse, no strobe, alu2acc and flags retain prior values. SHL A=0x8001 -> 0x0002, c=1.
